// File: rtl/ntt_loader_pkg.sv
// Shared types and defaults for the NTT lane loader.
// Software doorbell launch is enabled by NTT_LOADER_DOORBELL_EN.
package ntt_loader_pkg;

    localparam int DEF_LANES         = 8;
    localparam int DEF_WORD_W        = 32;
    localparam int DEF_N_COEFF       = 512;
    localparam int DEF_AW            = 14;
    localparam int DEF_BASE_ADDR     = 0;
    localparam int DEF_DOORBELL_ADDR = 512;

    localparam logic [31:0] DOORBELL_MAGIC = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DB_RD,
        S_DB_CHK,
        S_DB_CLR,
        S_FETCH,
        S_DONE
    } loader_state_t;

    typedef logic [DEF_LANES-1:0][DEF_WORD_W-1:0] lane_vec_t;

endpackage

// File: rtl/ntt_lane_packer.sv
// Packs fetched words into a lane beat and holds one finished
// beat in an output register on a valid/ready stream.
module ntt_lane_packer #(
    parameter int LANES  = 8,
    parameter int WORD_W = 32,
    parameter int SW     = 3
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    word_valid,
    input  logic [WORD_W-1:0]       word_data,
    input  logic [SW-1:0]           slot,
    input  logic                    last_beat,
    output logic                    pack_full,
    output logic                    lane_valid,
    input  logic                    lane_ready,
    output logic [LANES*WORD_W-1:0] lane_data,
    output logic                    lane_last
);

    logic [LANES-1:0][WORD_W-1:0] pack;
    logic [LANES-1:0][WORD_W-1:0] pack_nxt;
    logic                         held;
    logic                         take;

    always_comb begin
        pack_nxt = pack;
        if (word_valid) pack_nxt[slot] = word_data;
    end

    // The final word may bypass straight into the output register.
    assign pack_full = held || (word_valid && slot == SW'(LANES - 1));
    assign take      = pack_full && (!lane_valid || lane_ready);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pack       <= '0;
            held       <= 1'b0;
            lane_valid <= 1'b0;
            lane_data  <= '0;
            lane_last  <= 1'b0;
        end else begin
            pack <= pack_nxt;
            held <= pack_full && !take;
            if (take) begin
                lane_valid <= 1'b1;
                lane_data  <= pack_nxt;
                lane_last  <= last_beat;
            end else if (lane_ready) begin
                lane_valid <= 1'b0;
                lane_last  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ntt_lane_loader.sv
// Arbitrated read master that streams N_COEFF words as lane beats.
// NTT_LOADER_DOORBELL_EN adds a polled software doorbell launch.
module ntt_lane_loader
    import ntt_loader_pkg::*;
#(
    parameter int LANES         = DEF_LANES,
    parameter int WORD_W        = DEF_WORD_W,
    parameter int N_COEFF       = DEF_N_COEFF,
    parameter int AW            = DEF_AW,
    parameter int BASE_ADDR     = DEF_BASE_ADDR,
    parameter int DOORBELL_ADDR = DEF_DOORBELL_ADDR
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic [AW-1:0]           mem_addr,
    output logic                    mem_we,
    output logic [WORD_W-1:0]       mem_wdata,
    input  logic [WORD_W-1:0]       mem_rdata,
    output logic                    lane_valid,
    input  logic                    lane_ready,
    output logic [LANES*WORD_W-1:0] lane_data,
    output logic                    lane_last
);

    localparam int NB = N_COEFF / LANES;
    localparam int KW = $clog2(N_COEFF + 1);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = $clog2(LANES + 1);
    localparam int SW = (LANES > 1) ? $clog2(LANES) : 1;

    loader_state_t state;
    logic [KW-1:0] k;
    logic [CW-1:0] cnt;
    logic [BW-1:0] beat;
    logic          rd_pend;
    logic [SW-1:0] pend_slot;
    logic          pack_full;
    logic          pack_take;
    logic          fetch_req;
    logic          grant;

    // Issue for the next beat may start in the cycle the pack drains.
    assign pack_take = pack_full && (!lane_valid || lane_ready);
    assign fetch_req = state == S_FETCH && k < KW'(N_COEFF)
                    && (cnt < CW'(LANES) || pack_take);
    assign grant     = fetch_req && mem_gnt;
    assign mem_wdata = '0;

`ifdef NTT_LOADER_DOORBELL_EN
    logic start_pend;
    assign mem_req = fetch_req || state == S_DB_RD || state == S_DB_CLR;
    assign mem_we  = state == S_DB_CLR;
`else
    wire unused_db = ^DOORBELL_ADDR;
    assign mem_req = fetch_req;
    assign mem_we  = 1'b0;
`endif

    ntt_lane_packer #(
        .LANES (LANES),
        .WORD_W(WORD_W),
        .SW    (SW)
    ) u_packer (
        .clk       (clk),
        .resetn    (resetn),
        .word_valid(rd_pend),
        .word_data (mem_rdata),
        .slot      (pend_slot),
        .last_beat (beat == BW'(NB - 1)),
        .pack_full (pack_full),
        .lane_valid(lane_valid),
        .lane_ready(lane_ready),
        .lane_data (lane_data),
        .lane_last (lane_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            k         <= '0;
            cnt       <= '0;
            beat      <= '0;
            rd_pend   <= 1'b0;
            pend_slot <= '0;
`ifdef NTT_LOADER_DOORBELL_EN
            start_pend <= 1'b0;
`endif
        end else begin
            rd_pend   <= grant;
            pend_slot <= k[SW-1:0];
            done      <= 1'b0;
            if (grant) begin
                k        <= k + 1'b1;
                mem_addr <= mem_addr + 1'b1;
            end
            if (pack_take) begin
                cnt  <= grant ? CW'(1) : '0;
                beat <= beat + 1'b1;
            end else if (grant) begin
                cnt <= cnt + 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        busy     <= 1'b1;
                        mem_addr <= AW'(BASE_ADDR);
                        k        <= '0;
                        cnt      <= '0;
                        beat     <= '0;
                    end
`ifdef NTT_LOADER_DOORBELL_EN
                    else begin
                        state    <= S_DB_RD;
                        mem_addr <= AW'(DOORBELL_ADDR);
                    end
`endif
                end
                S_FETCH: begin
                    if (lane_valid && lane_ready && lane_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
`ifdef NTT_LOADER_DOORBELL_EN
                S_DB_RD: begin
                    if (start) start_pend <= 1'b1;
                    if (mem_gnt) state <= S_DB_CHK;
                end
                S_DB_CHK: begin
                    if (start || start_pend) begin
                        state      <= S_FETCH;
                        busy       <= 1'b1;
                        start_pend <= 1'b0;
                        mem_addr   <= AW'(BASE_ADDR);
                        k          <= '0;
                        cnt        <= '0;
                        beat       <= '0;
                    end else if (mem_rdata == DOORBELL_MAGIC) begin
                        state <= S_DB_CLR;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DB_CLR: begin
                    if (mem_gnt) begin
                        state      <= S_FETCH;
                        busy       <= 1'b1;
                        start_pend <= 1'b0;
                        mem_addr   <= AW'(BASE_ADDR);
                        k          <= '0;
                        cnt        <= '0;
                        beat       <= '0;
                    end
                end
`endif
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_lane_loader.sv
// Scoreboard bench for ntt_lane_loader: directed runs, random grant,
// output stall, mid-run reset, stray starts, optional doorbell.
module tb_ntt_lane_loader;
    import ntt_loader_pkg::*;

    localparam int LANES  = DEF_LANES;
    localparam int WORD_W = DEF_WORD_W;
    localparam int AW     = DEF_AW;
    localparam int NB     = DEF_N_COEFF / DEF_LANES;
    localparam int DW     = LANES * WORD_W;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic mem_gnt = 1'b1;
    logic lane_ready = 1'b1;
    logic busy, done, mem_req, mem_we, lane_valid, lane_last;
    logic [AW-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic [DW-1:0] lane_data;

    logic [WORD_W-1:0] mem [0:(1<<AW)-1];

    typedef struct packed {
        logic      last;
        lane_vec_t data;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int beats_seen = 0;
    int done_cnt = 0;
    int writes = 0;
    bit rand_gnt = 0;

    ntt_lane_loader dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .lane_valid(lane_valid),
        .lane_ready(lane_ready),
        .lane_data (lane_data),
        .lane_last (lane_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    // memory: read data appears the cycle after a granted read
    always @(posedge clk) begin
        if (mem_req && mem_gnt) begin
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
                writes++;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        mem_gnt = rand_gnt ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // monitor
    logic p_req = 0, p_gnt = 0, p_we = 0, p_valid = 0, p_ready = 0;
    logic p_last = 0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0;

    always @(negedge clk) begin
        beat_t e;
        if (resetn) begin
            if (p_req && !p_gnt)
                chk_i("req_hold", int'({mem_req, mem_we, mem_addr}),
                      int'({1'b1, p_we, p_addr}));
            if (p_valid && !p_ready) begin
                chk_i("valid_hold", int'({lane_valid, lane_last}),
                      int'({1'b1, p_last}));
                chk("data_hold", lane_data, p_data);
            end
            if (lane_valid && lane_ready) begin
                if (exp_q.size() == 0) begin
                    chk_i("unexpected_beat", beats_seen, -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", lane_data, e.data);
                    chk_i("beat_last", int'(lane_last), int'(e.last));
                end
                beats_seen++;
            end
            if (done) done_cnt++;
            p_req = mem_req; p_gnt = mem_gnt; p_we = mem_we;
            p_addr = mem_addr; p_valid = lane_valid; p_ready = lane_ready;
            p_data = lane_data; p_last = lane_last;
        end else begin
            p_req = 0;
            p_valid = 0;
        end
    end

    task automatic push_run();
        beat_t e;
        for (int b = 0; b < NB; b++) begin
            for (int i = 0; i < LANES; i++)
                e.data[i] = WORD_W'(32'h100 + b * LANES + i);
            e.last = (b == NB - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk_i({nm, "_done_seen"}, int'(done), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int target);
        int n;
        n = 0;
        while (beats_seen < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk_i("beat_wait", int'(beats_seen >= target), 1);
    endtask

    task automatic end_checks(input string nm, input int b0, input int d0);
        chk_i({nm, "_beats"}, beats_seen - b0, NB);
        chk_i({nm, "_done_once"}, done_cnt - d0, 1);
        chk_i({nm, "_queue"}, exp_q.size(), 0);
        chk_i({nm, "_busy"}, int'(busy), 0);
    endtask

    task automatic do_run(input string nm);
        int b0, d0;
        b0 = beats_seen;
        d0 = done_cnt;
        push_run();
        pulse_start();
        wait_done(nm);
        repeat (3) @(posedge clk);
        #1;
        end_checks(nm, b0, d0);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk_i({nm, "_ctl"},
              int'({busy, done, mem_req, mem_we, lane_valid, lane_last}), 0);
        chk_i({nm, "_addr"}, int'(mem_addr), 0);
        chk_i({nm, "_wdata"}, int'(mem_wdata), 0);
        chk({nm, "_lane_data"}, lane_data, '0);
    endtask

    initial begin
        int b0, d0, w0;
        for (int a = 0; a < (1 << AW); a++)
            mem[a] = (a < NB * LANES) ? WORD_W'(32'h100 + a) : '0;

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;
        @(posedge clk);
        #1;

        do_run("run_basic");

        rand_gnt = 1;
        do_run("run_gnt50");
        rand_gnt = 0;

        b0 = beats_seen;
        fork
            do_run("run_stall");
            begin
                wait_beats(b0 + 10);
                @(posedge clk);
                #1 lane_ready = 1'b0;
                repeat (20) @(posedge clk);
                @(negedge clk);
                chk_i("stall_req_off", int'(mem_req), 0);
                chk_i("stall_valid", int'(lane_valid), 1);
                @(posedge clk);
                #1 lane_ready = 1'b1;
            end
        join

        b0 = beats_seen;
        push_run();
        pulse_start();
        wait_beats(b0 + 30);
        #2 resetn = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk);
        #1;
        do_run("run_after_rst");

        b0 = beats_seen;
        d0 = done_cnt;
        push_run();
        pulse_start();
        repeat (100) @(posedge clk);
        #1;
        pulse_start();
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!done && n < 5000) begin
                @(negedge clk);
                n++;
            end
            chk_i("stray_done_seen", int'(done), 1);
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        end_checks("stray_start", b0, d0);
        chk_i("stray_idle_valid", int'(lane_valid), 0);

`ifdef NTT_LOADER_DOORBELL_EN
        w0 = writes;
        repeat (50) @(posedge clk);
        #1;
        chk_i("db_poll_writes", writes - w0, 0);
        chk_i("db_poll_busy", int'(busy), 0);

        b0 = beats_seen;
        d0 = done_cnt;
        push_run();
        mem[DEF_DOORBELL_ADDR] = 32'hFFFFFFFF;
        wait_done("db_run");
        chk_i("db_one_write", writes - w0, 1);
        chk_i("db_cleared", int'(mem[DEF_DOORBELL_ADDR]), 0);
        repeat (60) @(posedge clk);
        #1;
        end_checks("db_run", b0, d0);
        chk_i("db_no_second_write", writes - w0, 1);
`else
        w0 = writes;
        repeat (20) @(posedge clk);
        #1;
        chk_i("no_db_writes", writes - w0, 0);
        chk_i("no_db_busy", int'(busy), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
